// File: rtl/opfetch.sv
// Operand fetch stage: scoreboards destinations, reads sources from the register file
// with PC/writeback forwarding, and holds the fetched operands in a one-entry dispatch register.
module opfetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        iss_valid,
  output logic        iss_ready,
  input  logic [3:0]  iss_rs1,
  input  logic [3:0]  iss_rs2,
  input  logic        iss_rs1_en,
  input  logic        iss_rs2_en,
  input  logic [3:0]  iss_rd,
  input  logic        iss_rd_en,
  output logic [3:0]  out1_addr,
  output logic [3:0]  out2_addr,
  output logic        out1_en,
  output logic        out2_en,
  input  logic [15:0] out1,
  input  logic [15:0] out2,
  output logic        dsp_valid,
  input  logic        dsp_ready,
  output logic [15:0] dsp_op1,
  output logic [15:0] dsp_op2,
  output logic [3:0]  dsp_rd,
  output logic        dsp_rd_en,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [3:0]  wb_addr,
  input  logic [15:0] wb_data,
  input  logic        pcw_valid,
  input  logic [3:0]  pcw_addr,
  input  logic [15:0] pcw_data,
  output logic        w_en,
  output logic [3:0]  w_addr,
  output logic [15:0] w_data,
  output logic        pc_en,
  output logic [3:0]  pc_addr,
  output logic [15:0] pc_data
);

  logic [15:0] busy_reg;
  logic [15:0] busy_next;
  logic [15:0] busy_eff;
  logic [15:0] clr;
  logic [15:0] set;
  logic        hazard;
  logic        accept;
  logic [15:0] op1_next;
  logic [15:0] op2_next;

  logic        dsp_valid_reg;
  logic [15:0] dsp_op1_reg;
  logic [15:0] dsp_op2_reg;
  logic [3:0]  dsp_rd_reg;
  logic        dsp_rd_en_reg;

  assign out1_addr = iss_rs1;
  assign out2_addr = iss_rs2;
  assign out1_en   = iss_valid & iss_rs1_en;
  assign out2_en   = iss_valid & iss_rs2_en;

  assign pc_en   = pcw_valid & ~rst;
  assign pc_addr = pcw_addr;
  assign pc_data = pcw_data;

  // The register file has a single general write slot shared with PC writes; PC wins.
  assign wb_ready = ~pcw_valid & ~rst;
  assign w_en     = wb_valid & wb_ready;
  assign w_addr   = wb_addr;
  assign w_data   = wb_data;

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_sb
      assign clr[gi] = w_en & (wb_addr == 4'(gi));
      assign set[gi] = accept & iss_rd_en & (iss_rd == 4'(gi));
    end
  endgenerate

  // A writeback completing this cycle already releases its register for the issuing op.
  assign busy_eff = busy_reg & ~clr;
  assign hazard   = (iss_rs1_en & busy_eff[iss_rs1]) |
                    (iss_rs2_en & busy_eff[iss_rs2]) |
                    (iss_rd_en  & busy_eff[iss_rd]);

  assign iss_ready = ~rst & ~hazard & (~dsp_valid_reg | dsp_ready);
  assign accept    = iss_valid & iss_ready;
  assign busy_next = busy_eff | set;

  function automatic logic [15:0] sel_op(
    input logic        en,
    input logic [3:0]  rs,
    input logic [15:0] rf_data,
    input logic        pcv,
    input logic [3:0]  pca,
    input logic [15:0] pcd,
    input logic        wv,
    input logic [3:0]  wa,
    input logic [15:0] wd
  );
    logic [15:0] r;
    r = rf_data;
    if (!en)                  r = 16'h0000;
    else if (pcv && pca == rs) r = pcd;
    else if (wv && wa == rs)   r = wd;
    return r;
  endfunction

  assign op1_next = sel_op(iss_rs1_en, iss_rs1, out1, pcw_valid, pcw_addr, pcw_data,
                           w_en, wb_addr, wb_data);
  assign op2_next = sel_op(iss_rs2_en, iss_rs2, out2, pcw_valid, pcw_addr, pcw_data,
                           w_en, wb_addr, wb_data);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg      <= '0;
      dsp_valid_reg <= 1'b0;
      dsp_op1_reg   <= '0;
      dsp_op2_reg   <= '0;
      dsp_rd_reg    <= '0;
      dsp_rd_en_reg <= 1'b0;
    end else begin
      busy_reg <= busy_next;
      if (accept) begin
        dsp_valid_reg <= 1'b1;
        dsp_op1_reg   <= op1_next;
        dsp_op2_reg   <= op2_next;
        dsp_rd_reg    <= iss_rd;
        dsp_rd_en_reg <= iss_rd_en;
      end else if (dsp_ready) begin
        dsp_valid_reg <= 1'b0;
      end
    end
  end

  assign dsp_valid = dsp_valid_reg;
  assign dsp_op1   = dsp_op1_reg;
  assign dsp_op2   = dsp_op2_reg;
  assign dsp_rd    = dsp_rd_reg;
  assign dsp_rd_en = dsp_rd_en_reg;

endmodule

// File: tb/tb_opfetch.sv
// Bench for opfetch: directed scenarios plus random traffic, checked by a queue-based
// scoreboard against a register-level model of the architectural state.
module tb_opfetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iss_valid = 1'b0, iss_ready;
  logic [3:0]  iss_rs1 = '0, iss_rs2 = '0, iss_rd = '0;
  logic        iss_rs1_en = 1'b0, iss_rs2_en = 1'b0, iss_rd_en = 1'b0;
  logic [3:0]  out1_addr, out2_addr;
  logic        out1_en, out2_en;
  logic [15:0] out1, out2;
  logic        dsp_valid, dsp_ready = 1'b0;
  logic [15:0] dsp_op1, dsp_op2;
  logic [3:0]  dsp_rd;
  logic        dsp_rd_en;
  logic        wb_valid = 1'b0, wb_ready;
  logic [3:0]  wb_addr = '0;
  logic [15:0] wb_data = '0;
  logic        pcw_valid = 1'b0;
  logic [3:0]  pcw_addr = '0;
  logic [15:0] pcw_data = '0;
  logic        w_en, pc_en;
  logic [3:0]  w_addr, pc_addr;
  logic [15:0] w_data, pc_data;

  opfetch dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_rs1_en(iss_rs1_en), .iss_rs2_en(iss_rs2_en),
    .iss_rd(iss_rd), .iss_rd_en(iss_rd_en),
    .out1_addr(out1_addr), .out2_addr(out2_addr),
    .out1_en(out1_en), .out2_en(out2_en),
    .out1(out1), .out2(out2),
    .dsp_valid(dsp_valid), .dsp_ready(dsp_ready),
    .dsp_op1(dsp_op1), .dsp_op2(dsp_op2),
    .dsp_rd(dsp_rd), .dsp_rd_en(dsp_rd_en),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_addr(wb_addr), .wb_data(wb_data),
    .pcw_valid(pcw_valid), .pcw_addr(pcw_addr), .pcw_data(pcw_data),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .pc_en(pc_en), .pc_addr(pc_addr), .pc_data(pc_data)
  );

  always #5 clk = ~clk;

  // Register file driven by the DUT's write ports; read combinationally.
  logic [15:0] rf [16];
  logic [15:0] init_vals [16];
  logic        rf_load = 1'b1;
  assign out1 = rf[out1_addr];
  assign out2 = rf[out2_addr];
  always @(posedge clk) begin
    if (rf_load) begin
      for (int i = 0; i < 16; i++) rf[i] <= init_vals[i];
    end else begin
      if (pc_en) rf[pc_addr] <= pc_data;
      if (w_en)  rf[w_addr]  <= w_data;
    end
  end

  typedef struct packed {
    logic [15:0] op1;
    logic [15:0] op2;
    logic [3:0]  rd;
    logic        rd_en;
  } exp_t;

  typedef struct packed {
    bit r, iv;
    bit [3:0] a1; bit e1;
    bit [3:0] a2; bit e2;
    bit [3:0] d;  bit de;
    bit dr, wv;
    bit [3:0] wa; bit [15:0] wd;
    bit pv;
    bit [3:0] pa; bit [15:0] pd;
  } stim_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_rf [16];
  bit          m_busy [16];
  bit          m_dv = 1'b0;
  bit          m_zero = 1'b0;
  bit          m_known = 1'b0;

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // One clock of stimulus; expectations come from the architectural model.
  task automatic run(input stim_t s);
    bit wacc, haz, rdy, acc;
    logic [15:0] nrf [16];
    @(posedge clk); #1;
    rst = s.r; iss_valid = s.iv;
    iss_rs1 = s.a1; iss_rs1_en = s.e1; iss_rs2 = s.a2; iss_rs2_en = s.e2;
    iss_rd = s.d; iss_rd_en = s.de; dsp_ready = s.dr;
    wb_valid = s.wv; wb_addr = s.wa; wb_data = s.wd;
    pcw_valid = s.pv; pcw_addr = s.pa; pcw_data = s.pd;
    @(negedge clk);
    wacc = !s.r && s.wv && !s.pv;
    haz  = (s.e1 && m_busy[s.a1] && !(wacc && s.wa == s.a1)) ||
           (s.e2 && m_busy[s.a2] && !(wacc && s.wa == s.a2)) ||
           (s.de && m_busy[s.d]  && !(wacc && s.wa == s.d));
    rdy  = !s.r && !haz && (!m_dv || s.dr);
    acc  = s.iv && rdy;
    chk("iss_ready", 48'(iss_ready), 48'(rdy));
    chk("wb_ready",  48'(wb_ready),  48'(!s.r && !s.pv));
    chk("w_en",      48'(w_en),      48'(wacc));
    chk("pc_en",     48'(pc_en),     48'(!s.r && s.pv));
    chk("rd_ports",  48'({out1_en, out1_addr, out2_en, out2_addr}),
                     48'({s.iv && s.e1, s.a1, s.iv && s.e2, s.a2}));
    if (wacc) chk("w_port", 48'({w_addr, w_data}), 48'({s.wa, s.wd}));
    if (s.pv && !s.r) chk("pc_port", 48'({pc_addr, pc_data}), 48'({s.pa, s.pd}));
    if (m_known) chk("dsp_valid", 48'(dsp_valid), 48'(m_dv));
    if (m_known && m_zero)
      chk("dsp_reset_vals", 48'({dsp_op1, dsp_op2, dsp_rd, dsp_rd_en}), 48'(0));
    nrf = m_rf;
    if (!s.r && s.pv) nrf[s.pa] = s.pd;
    else if (wacc)    nrf[s.wa] = s.wd;
    if (s.r) begin
      for (int i = 0; i < 16; i++) m_busy[i] = 1'b0;
      m_dv = 1'b0; m_zero = 1'b1; m_known = 1'b1;
      exp_q.delete();
    end else begin
      if (wacc) m_busy[s.wa] = 1'b0;
      if (acc && s.de) m_busy[s.d] = 1'b1;
      if (acc) begin
        exp_q.push_back({s.e1 ? nrf[s.a1] : 16'h0000, s.e2 ? nrf[s.a2] : 16'h0000, s.d, s.de});
        m_zero = 1'b0;
      end
      m_dv = acc || (m_dv && !s.dr);
    end
    m_rf = nrf;
  endtask

  // Monitor: every presented dispatch must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && dsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL dsp_unexpected actual=%0h required=none", dsp_op1);
      end else begin
        chk("dsp_op1", 48'(dsp_op1), 48'(exp_q[0].op1));
        chk("dsp_op2", 48'(dsp_op2), 48'(exp_q[0].op2));
        chk("dsp_rd",  48'({dsp_rd, dsp_rd_en}), 48'({exp_q[0].rd, exp_q[0].rd_en}));
        if (dsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    stim_t s;
    for (int i = 0; i < 16; i++) begin
      init_vals[i] = 16'($urandom);
      m_busy[i] = 1'b0;
    end
    init_vals[2] = 16'h0011;
    init_vals[3] = 16'h0022;
    for (int i = 0; i < 16; i++) m_rf[i] = init_vals[i];

    s = '0; s.r = 1'b1;
    run(s);
    rf_load = 1'b0;
    run(s);

    // Basic fetch of r2/r3
    s = '0; s.iv = 1; s.a1 = 2; s.e1 = 1; s.a2 = 3; s.e2 = 1; s.dr = 1;
    run(s);
    // Producer of r5, then a consumer stalled until writeback of r5
    s = '0; s.iv = 1; s.d = 5; s.de = 1; s.dr = 1;
    run(s);
    s = '0; s.iv = 1; s.a1 = 5; s.e1 = 1; s.dr = 1;
    repeat (3) run(s);
    s.wv = 1; s.wa = 5; s.wd = 16'hBEEF;
    run(s);
    // PC write collides with writeback; writeback retried next cycle
    s = '0; s.dr = 1; s.pv = 1; s.pa = 9; s.pd = 16'h1234; s.wv = 1; s.wa = 4; s.wd = 16'h4444;
    run(s);
    s.pv = 0;
    run(s);
    // Downstream stall for 3 cycles, then drain with a same-cycle accept
    s = '0; s.iv = 1; s.a1 = 9; s.e1 = 1; s.a2 = 4; s.e2 = 1;
    run(s);
    s.a1 = 1;
    repeat (3) run(s);
    s.dr = 1;
    run(s);
    // Set and clear of r7 in the same cycle: set wins
    s = '0; s.iv = 1; s.d = 7; s.de = 1; s.dr = 1;
    run(s);
    s.wv = 1; s.wa = 7; s.wd = 16'h7777;
    run(s);
    s = '0; s.iv = 1; s.a1 = 7; s.e1 = 1; s.dr = 0;
    repeat (2) run(s);
    s.r = 1;
    run(s);
    s.r = 0; s.dr = 1;
    run(s);
    // Disabled sources read as zero
    s = '0; s.iv = 1; s.a1 = 2; s.a2 = 3; s.dr = 1;
    run(s);

    for (int n = 0; n < 600; n++) begin
      s = '0;
      s.r  = ($urandom_range(0, 63) == 0);
      s.iv = ($urandom_range(0, 3) != 0);
      s.a1 = 4'($urandom_range(0, 7)); s.e1 = 1'($urandom);
      s.a2 = 4'($urandom_range(0, 7)); s.e2 = 1'($urandom);
      s.d  = 4'($urandom_range(0, 7)); s.de = 1'($urandom);
      s.dr = ($urandom_range(0, 3) != 0);
      s.wv = 1'($urandom);
      s.wa = 4'($urandom_range(0, 7)); s.wd = 16'($urandom);
      s.pv = ($urandom_range(0, 6) == 0);
      s.pa = 4'($urandom_range(0, 15)); s.pd = 16'($urandom);
      run(s);
    end
    s = '0; s.dr = 1;
    repeat (3) run(s);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/opfetch.md
OPFETCH -- requirements
Module: opfetch

Interface
REQ-001 SHALL have parameters: none; data width fixed 16, register address width fixed 4 (16 registers).
REQ-002 SHALL have ports (name  direction  width  meaning):
 clk  in  1  single clock, all state on rising edge
 rst  in  1  synchronous, active-high reset
 iss_valid  in  1  issue request valid
 iss_ready  out  1  issue accepted this cycle when valid&ready
 iss_rs1 / iss_rs2  in  4 each  source register addresses
 iss_rs1_en / iss_rs2_en  in  1 each  source operand used
 iss_rd  in  4  destination register
 iss_rd_en  in  1  destination written later by writeback
 out1_addr / out2_addr  out  4 each  register-file read addresses
 out1_en / out2_en  out  1 each  register-file read enables
 out1 / out2  in  16 each  register-file combinational read data
 dsp_valid  out  1  dispatch operands valid
 dsp_ready  in  1  downstream accepts dispatch
 dsp_op1 / dsp_op2  out  16 each  fetched operands
 dsp_rd  out  4  destination register of dispatched op
 dsp_rd_en  out  1  destination valid
 wb_valid  in  1  writeback request
 wb_ready  out  1  writeback accepted when valid&ready
 wb_addr  in  4;  wb_data  in  16  writeback target/data
 pcw_valid  in  1  PC-register write (always accepted)
 pcw_addr  in  4;  pcw_data  in  16  PC write target/data
 w_en  out  1;  w_addr  out  4;  w_data  out  16  register-file general write port
 pc_en  out  1;  pc_addr  out  4;  pc_data  out  16  register-file PC write port

Function
REQ-003 SHALL keep a 16-bit scoreboard busy[15:0]; busy[r]=1 means a dispatched/issued op will write r.
REQ-004 SHALL drive out1_addr=iss_rs1, out1_en=iss_valid&iss_rs1_en, out2_addr=iss_rs2, out2_en=iss_valid&iss_rs2_en, combinationally.
REQ-005 SHALL pass pcw_* straight through: pc_en=pcw_valid&~rst, pc_addr=pcw_addr, pc_data=pcw_data.
REQ-006 SHALL drive wb_ready=~pcw_valid&~rst (register file gives PC priority); w_en=wb_valid&wb_ready, w_addr=wb_addr, w_data=wb_data.
REQ-007 SHALL define clr[r]=w_en&(wb_addr==r) for the current cycle.
REQ-008 SHALL define hazard = (rs1_en&busy'[rs1]) | (rs2_en&busy'[rs2]) | (rd_en&busy'[rd]), where busy'=busy&~clr.
REQ-009 SHALL assert iss_ready = ~rst & ~hazard & (~dsp_valid | dsp_ready); no dependency of iss_ready on iss_valid.
REQ-010 SHALL, on issue accept, capture operands into output register with latency 1: dsp_valid=1 next cycle.
REQ-011 SHALL select each operand as: source disabled -> 16'h0000; else pcw_valid & pcw_addr==rs -> pcw_data; else w_en & wb_addr==rs -> wb_data; else outN.
REQ-012 SHALL hold dsp_* stable while dsp_valid&~dsp_ready; SHALL clear dsp_valid when dsp_ready and no new accept; back-to-back accept each cycle allowed when dsp_ready=1.
REQ-013 SHALL set busy[iss_rd] on issue accept with iss_rd_en; SHALL clear busy[wb_addr] on w_en; simultaneous set and clear of same register -> set wins.
REQ-014 SHALL not track pcw writes in scoreboard; pcw to a busy register leaves busy unchanged.
REQ-015 SHALL accept wb to a non-busy register (write performed, busy stays 0).
REQ-016 SHALL have no combinational path from dsp_ready to dsp_* data.

Reset
REQ-017 SHALL, while rst=1 at a clock edge, set busy=0, dsp_valid=0, dsp_op1=dsp_op2=0, dsp_rd=0, dsp_rd_en=0.
REQ-018 SHALL hold iss_ready=0, wb_ready=0, w_en=0, pc_en=0 while rst=1; an in-flight dispatch is discarded.

Verification
REQ-019 Reset then issue rs1=2,rs2=3 (rf r2=0x0011,r3=0x0022), dsp_ready=1 -> next cycle dsp_valid=1, op1=0x0011, op2=0x0022.
REQ-020 Issue rd=5 rd_en=1, then issue rs1=5 -> iss_ready=0 until wb_addr=5 accepted; in that wb cycle iss_ready=1 and op1=wb_data (e.g. 0xBEEF).
REQ-021 pcw_valid and wb_valid same cycle -> pc_en=1, w_en=0, wb_ready=0; wb accepted following cycle.
REQ-022 dsp_ready=0 for 3 cycles with dsp_valid=1 -> dsp_* unchanged, iss_ready=0; dsp_ready=1 -> pending drained and next issue accepted same cycle.
REQ-023 Issue rd=7 while wb_addr=7 accepted same cycle (busy[7]=1 before) -> busy[7]=1 after; rst mid-stall -> busy=0, dsp_valid=0 next cycle.
REQ-024 Issue with rs1_en=rs2_en=0 -> op1=op2=0x0000, out1_en=out2_en=0.
